sm4_engine_arbiter: RTL

- Shares one SM4 core (encryptor or decryptor instance) between two independent requesters. Each requester supplies its own master key.
- Round-robin arbitration; one block in flight at a time.
- Reloads the core's key only when the granted key differs from the key currently loaded. Gives up on a stalled core after a timeout.
- Sits between client logic (DMA / bus slaves) and the SM4 core; drives the core's MK/DAT valid inputs and consumes its DAT/READY outputs.

---
 rtl/sm4_arb_pkg.sv | 17 +
 rtl/sm4_rr_arbiter.sv | 42 ++++
 rtl/sm4_engine_arbiter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/sm4_arb_pkg.sv
// Shared types and constants for the SM4 engine arbiter slice.
package sm4_arb_pkg;

  localparam int STATE_W   = 3;
  localparam int REQ_IDX_W = 1;
  localparam int BLK_W     = 128;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_ACCEPT   = 3'd1,
    ST_KEY_LOAD = 3'd2,
    ST_ISSUE    = 3'd3,
    ST_WAIT     = 3'd4,
    ST_RESP     = 3'd5
  } state_e;

endpackage

// File: rtl/sm4_rr_arbiter.sv
// Two-way round-robin grant. The candidate grant is combinational; it is
// committed (and the tie-break pointer flipped) only when 'take' is high.
module sm4_rr_arbiter
  import sm4_arb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           req,
  input  logic                 take,
  output logic                 any_req,
  output logic [REQ_IDX_W-1:0] grant,
  output logic [REQ_IDX_W-1:0] last_grant
);

  // Index that wins when both requesters are active; 0 after reset.
  logic prio;

  // Candidate grant: a lone requester wins, a tie goes to the pointer.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    grant   = 1'b0;
    any_req = |req;
    if (req == 2'b11) begin
      grant = prio;
    end else if (req[1]) begin
      grant = 1'b1;
    end
  end

  // Commit the grant and hand the tie-break to the other requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b0;
      prio       <= 1'b0;
    end else if (take) begin
      // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
      last_grant <= grant;
      prio       <= ~grant;
    end
  end

endmodule

// File: rtl/sm4_engine_arbiter.sv
// Shares one SM4 core between two requesters: round-robin grant, one block
// in flight, key reload only on a key change, timeout on a stalled core.
module sm4_engine_arbiter
  import sm4_arb_pkg::*;
#(
  parameter int KEY_CYCLES = 32,
  parameter int TIMEOUT    = 64,
  parameter int CNT_W      = 16
) (
  input  logic             CLK_i,
  input  logic             RST_N_i,
  input  logic             REQ0_VALID_i,
  output logic             REQ0_READY_o,
  input  logic [BLK_W-1:0] REQ0_MK_i,
  input  logic [BLK_W-1:0] REQ0_DAT_i,
  input  logic             REQ1_VALID_i,
  output logic             REQ1_READY_o,
  input  logic [BLK_W-1:0] REQ1_MK_i,
  input  logic [BLK_W-1:0] REQ1_DAT_i,
  output logic             RSP0_VALID_o,
  output logic             RSP0_ERR_o,
  output logic             RSP1_VALID_o,
  output logic             RSP1_ERR_o,
  output logic [BLK_W-1:0] RSP_DAT_o,
  output logic [BLK_W-1:0] ENG_MK_o,
  output logic             ENG_MK_VALID_o,
  output logic [BLK_W-1:0] ENG_DAT_o,
  output logic             ENG_DAT_VALID_o,
  input  logic [BLK_W-1:0] ENG_DAT_i,
  input  logic             ENG_DAT_READY_i,
  output logic             BUSY_o,
  output logic             GRANT_o
);

  localparam logic [7:0]       KEY_LAST = 8'(KEY_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);

  state_e                 state_q, state_d;
  logic [1:0]             req_vec;
  logic                   any_req, take;
  logic [REQ_IDX_W-1:0]   cand, grant_q;
  logic [BLK_W-1:0]       sel_mk, sel_dat;
  logic [BLK_W-1:0]       mk_lat, dat_lat, loaded_key, rsp_dat_q, eng_mk_q;
  logic                   key_loaded, rsp_err_q, eng_mk_valid_q, eng_dat_valid_q;
  logic [7:0]             key_cnt;
  logic [CNT_W-1:0]       to_cnt;
  logic                   key_miss, key_done, wait_timeout;

  assign req_vec = {REQ1_VALID_i, REQ0_VALID_i};
  assign take    = (state_q == ST_IDLE) && any_req;

  sm4_rr_arbiter u_arb (
    .clk        (CLK_i),
    .rst_n      (RST_N_i),
    .req        (req_vec),
    .take       (take),
    .any_req    (any_req),
    .grant      (cand),
    .last_grant (grant_q)
  );

  // The granted requester's inputs are only meaningful during ACCEPT.
  assign sel_mk       = (grant_q == 1'b1) ? REQ1_MK_i  : REQ0_MK_i;
  assign sel_dat      = (grant_q == 1'b1) ? REQ1_DAT_i : REQ0_DAT_i;
  assign key_miss     = !key_loaded || (sel_mk != loaded_key);
  assign key_done     = (key_cnt == KEY_LAST);
  assign wait_timeout = (to_cnt == TO_LAST);

  // State register.
  always_ff @(posedge CLK_i or negedge RST_N_i) begin
    if (!RST_N_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; a core result beats a timeout in the same WAIT cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (any_req) state_d = ST_ACCEPT;
      ST_ACCEPT:   state_d = key_miss ? ST_KEY_LOAD : ST_ISSUE;
      ST_KEY_LOAD: if (key_done) state_d = ST_ISSUE;
      ST_ISSUE:    state_d = ST_WAIT;
      ST_WAIT:     if (ENG_DAT_READY_i || wait_timeout) state_d = ST_RESP;
      ST_RESP:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the current state and grant.
  always_comb begin
    REQ0_READY_o = 1'b0;
    REQ1_READY_o = 1'b0;
    RSP0_VALID_o = 1'b0;
    RSP1_VALID_o = 1'b0;
    if (state_q == ST_ACCEPT) begin
      REQ0_READY_o = (grant_q == 1'b0);
      REQ1_READY_o = (grant_q == 1'b1);
    end
    if (state_q == ST_RESP) begin
      RSP0_VALID_o = (grant_q == 1'b0);
      RSP1_VALID_o = (grant_q == 1'b1);
    end
    RSP0_ERR_o = RSP0_VALID_o & rsp_err_q;
    RSP1_ERR_o = RSP1_VALID_o & rsp_err_q;
    BUSY_o     = (state_q != ST_IDLE);
    GRANT_o    = grant_q;
  end

  // Block/key latching, key-expansion and timeout counters, result capture.
  always_ff @(posedge CLK_i or negedge RST_N_i) begin
    if (!RST_N_i) begin
      // NOTE: the 128-bit holding registers are reset too, so every output reads 0 out of reset.
      mk_lat     <= '0;
      dat_lat    <= '0;
      loaded_key <= '0;
      key_loaded <= 1'b0;
      key_cnt    <= '0;
      to_cnt     <= '0;
      rsp_dat_q  <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_ACCEPT: begin
          mk_lat  <= sel_mk;
          dat_lat <= sel_dat;
          key_cnt <= '0;
        end
        ST_KEY_LOAD: begin
          key_cnt <= key_cnt + 8'd1;
          if (key_done) begin
            loaded_key <= mk_lat;
            key_loaded <= 1'b1;
          end
        end
        ST_ISSUE: to_cnt <= '0;
        ST_WAIT: begin
          if (ENG_DAT_READY_i) begin
            rsp_dat_q <= ENG_DAT_i;
            rsp_err_q <= 1'b0;
          end else if (wait_timeout) begin
            // A stalled core may hold a corrupt schedule: force a reload next time.
            rsp_dat_q  <= '0;
            rsp_err_q  <= 1'b1;
            key_loaded <= 1'b0;
          end else begin
            to_cnt <= to_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Registered core interface: key valid starts one cycle into KEY_LOAD and
  // lasts KEY_CYCLES cycles before the issue pulse; it then tracks key_loaded.
  always_ff @(posedge CLK_i or negedge RST_N_i) begin
    if (!RST_N_i) begin
      eng_mk_q        <= '0;
      eng_mk_valid_q  <= 1'b0;
      eng_dat_valid_q <= 1'b0;
    end else begin
      eng_mk_q        <= (state_q == ST_KEY_LOAD) ? mk_lat : loaded_key;
      eng_mk_valid_q  <= (state_q == ST_KEY_LOAD) || key_loaded;
      eng_dat_valid_q <= (state_q == ST_ISSUE);
    end
  end

  assign ENG_MK_o        = eng_mk_q;
  assign ENG_MK_VALID_o  = eng_mk_valid_q;
  assign ENG_DAT_o       = dat_lat;
  assign ENG_DAT_VALID_o = eng_dat_valid_q;
  assign RSP_DAT_o       = rsp_dat_q;

endmodule
